// File: rtl/core_pkg.sv
// Shared constants for the MIPS core pipeline control: FSM encoding, register
// indices and MDU timing defaults.
package core_pkg;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MDU_WAIT = 1'b1;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MDU_LAT_DEFAULT = 32;

  typedef logic [4:0] reg_idx_t;

  // A source operand depends on a producer only if it is actually read.
  function automatic logic reg_match(input logic used, input reg_idx_t src, input reg_idx_t dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// Fixed-latency MDU occupancy tracker: loads the latency on a start pulse and
// counts down, holding busy high for exactly MDU_LAT cycles after the start.
module mdu_timer
  import core_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT,
  parameter int LAT_W   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MDU_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  logic [0:0]       r_state;
  logic [LAT_W-1:0] r_lat_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_lat_cnt <= '0;
    end else if (start) begin
      r_state   <= ST_MDU_WAIT;
      r_lat_cnt <= LAT_INIT;
    end else if (r_state == ST_MDU_WAIT) begin
      if (r_lat_cnt == LAT_ONE) begin
        r_lat_cnt <= '0;
        r_state   <= ST_RUN;
      end else begin
        r_lat_cnt <= r_lat_cnt - LAT_ONE;
      end
    end
  end

  assign busy = (r_state == ST_MDU_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use and MDU interlocks, redirect
// flush of IF/ID, and a saturating stall-cycle counter.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MDU_LAT     = MDU_LAT_DEFAULT,
  parameter int LAT_W       = 6,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rt,
  input  logic                   id_is_mdu,
  input  logic                   id_is_hilo,
  input  logic                   id_redirect,
  output logic                   PC_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   mdu_start,
  output logic                   mdu_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic                   w_load_use;
  logic                   w_mdu_hold;
  logic                   w_stall;
  logic                   w_mdu_busy;
  logic [STALL_CNT_W-1:0] r_stall_count;

  // A load into $0 produces nothing a later instruction could depend on.
  assign w_load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      (reg_match(id_uses_rs, id_rs, ex_rt) ||
                       reg_match(id_uses_rt, id_rt, ex_rt));
  assign w_mdu_hold = w_mdu_busy && (id_is_mdu || id_is_hilo);
  assign w_stall    = w_load_use || w_mdu_hold;

  assign PC_write   = ~w_stall;
  assign ifid_write = ~w_stall;
  assign idex_flush = w_stall;
  assign ifid_flush = id_redirect && !w_stall;
  assign mdu_start  = id_is_mdu && !w_stall;
  assign mdu_busy   = w_mdu_busy;

  mdu_timer #(
    .MDU_LAT (MDU_LAT),
    .LAT_W   (LAT_W)
  ) u_mdu_timer (
    .clk   (clk),
    .rst   (rst),
    .start (mdu_start),
    .busy  (w_mdu_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_ONE;
    end
  end

  assign stall_count = r_stall_count;

endmodule
